// File: rtl/fmas_pkg.sv
// Shared types and constants for the fmas writeback/retire stage.
package fmas_pkg;

  // Cycles from fmas.req to valid rslt/flag.
  localparam int FMAS_LAT = 2;

  // Destination tag width carried through the result FIFO.
  localparam int FMAS_TAGW = 5;

  // IEEE exception flag bit positions in flag / fflags.
  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  // One retired result as held in the FIFO.
  typedef struct packed {
    logic [FMAS_TAGW-1:0] tag;
    logic [31:0]          data;
    logic [4:0]           flag;
  } wb_entry_t;

endpackage

// File: rtl/fmas_wb_fifo.sv
// In-order result FIFO; head is read straight from storage (no bypass).
// DEPTH must be a power of two and at least 2.
module fmas_wb_fifo
  import fmas_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  wb_entry_t   mem [DEPTH];

  logic do_pop;
  assign do_pop = pop & ~empty;

  // Pointer update; reset drops all queued entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; contents need no reset since validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/fmas_wb.sv
// Writeback/retire stage behind fmas: shadows issued tags for LAT cycles,
// captures rslt/flag into an in-order FIFO, owns issue credits and fflags.
module fmas_wb
  import fmas_pkg::*;
#(
  parameter int TAGW  = FMAS_TAGW,
  parameter int DEPTH = 4,
  parameter int LAT   = FMAS_LAT
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [TAGW-1:0] req_tag,
  output logic            req_ready,
  input  logic [31:0]     rslt,
  input  logic [4:0]      flag,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [TAGW-1:0] wb_tag,
  output logic [31:0]     wb_data,
  output logic [4:0]      wb_flag,
  output logic [4:0]      fflags,
  input  logic            fflags_clr,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [LAT-1:0]  stage_valid_reg;
  logic [TAGW-1:0] stage_tag_reg [LAT];
  logic [CW-1:0]   cnt_reg;
  logic [4:0]      fflags_reg;
  logic            err_reg;

  logic      accept;
  logic      pop;
  logic      capture;
  logic      fifo_empty;
  logic      fifo_full;
  wb_entry_t push_entry;
  wb_entry_t head;

  assign req_ready = (cnt_reg < CW'(DEPTH));
  assign accept    = req & req_ready;
  assign pop       = wb_valid & wb_ready;
  assign capture   = stage_valid_reg[LAT-1];

  // Valid bits of the tag shadow pipeline; shifts every cycle, never stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_valid_reg <= '0;
    end else begin
      stage_valid_reg[0] <= accept;
      for (int i = 1; i < LAT; i++) stage_valid_reg[i] <= stage_valid_reg[i-1];
    end
  end

  // Tags ride alongside the valid bits; meaningless where the valid is low.
  always_ff @(posedge clk) begin
    stage_tag_reg[0] <= req_tag;
    for (int i = 1; i < LAT; i++) stage_tag_reg[i] <= stage_tag_reg[i-1];
  end

  assign push_entry = '{tag: FMAS_TAGW'(stage_tag_reg[LAT-1]), data: rslt, flag: flag};

  // Credits cover in-flight plus queued results, so a push never meets full;
  // the full gate only protects storage if that invariant were ever broken.
  fmas_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture & ~fifo_full),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign wb_valid = ~fifo_empty;
  assign wb_tag   = TAGW'(head.tag);
  assign wb_data  = head.data;
  assign wb_flag  = head.flag;

  // Issue credit counter: up on accept, down on pop, hold when both.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Sticky exception flags; a popped flag survives a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fflags_reg <= '0;
    end else if (pop) begin
      fflags_reg <= (fflags_clr ? 5'b0 : fflags_reg) | head.flag;
    end else if (fflags_clr) begin
      fflags_reg <= '0;
    end
  end

  // Sticky protocol error: request issued while no credit was available.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (req & ~req_ready) begin
      err_reg <= 1'b1;
    end
  end

  assign fflags = fflags_reg;
  assign err    = err_reg;
  assign busy   = (|stage_valid_reg) | ~fifo_empty;

endmodule

// File: tb/tb_fmas_wb.sv
// Randomised + directed bench for fmas_wb. The bench plays the fmas unit
// (drives rslt/flag LAT cycles after each req) and keeps a queue-based model.
module tb_fmas_wb;
  import fmas_pkg::*;

  localparam int TAGW  = 5;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            req;
  logic [TAGW-1:0] req_tag;
  logic            req_ready;
  logic [31:0]     rslt;
  logic [4:0]      flag;
  logic            wb_valid;
  logic            wb_ready;
  logic [TAGW-1:0] wb_tag;
  logic [31:0]     wb_data;
  logic [4:0]      wb_flag;
  logic [4:0]      fflags;
  logic            fflags_clr;
  logic            busy;
  logic            err;

  always #5 clk = ~clk;

  fmas_wb #(.TAGW(TAGW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rslt       (rslt),
    .flag       (flag),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_tag     (wb_tag),
    .wb_data    (wb_data),
    .wb_flag    (wb_flag),
    .fflags     (fflags),
    .fflags_clr (fflags_clr),
    .busy       (busy),
    .err        (err)
  );

  // Model: every accepted request is outstanding until popped; it becomes
  // visible at the head LAT+1 cycles after issue.
  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic [4:0]  flg;
    int          due;
  } ment_t;

  ment_t       mq[$];
  logic [36:0] sched [int];
  int          cyc;
  bit          run;
  logic [4:0]  ff_m;
  logic        err_m;

  logic        exp_valid, exp_ready, exp_busy, exp_err;
  logic [4:0]  exp_fflags;
  ment_t       exp_head;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } pin_t;
  pin_t pins [512];
  int   pin_wr;
  int   pin_rd;

  int n_checks;
  int n_fail;

  task automatic publish();
    exp_valid  = (mq.size() > 0) && (mq[0].due <= cyc);
    if (exp_valid) exp_head = mq[0];
    exp_ready  = (mq.size() < DEPTH);
    exp_busy   = (mq.size() > 0);
    exp_err    = err_m;
    exp_fflags = ff_m;
  endtask

  // One cycle: drive inputs, advance the model across the edge.
  task automatic step(input bit rq, input logic [4:0] tg, input bit wr, input bit clr,
                      input bit rn, input logic [31:0] d, input logic [4:0] f);
    req = rq; req_tag = tg; wb_ready = wr; fflags_clr = clr; reset = rn;
    if (sched.exists(cyc)) begin
      {rslt, flag} = sched[cyc];
      sched.delete(cyc);
    end else begin
      rslt = $urandom;
      flag = 5'($urandom);
    end
    if (rq) sched[cyc + LAT] = {d, f};
    if (!rn) begin
      mq.delete();
      ff_m  = 5'd0;
      err_m = 1'b0;
    end else begin
      if (exp_valid && wr) begin
        ff_m = (clr ? 5'd0 : ff_m) | mq[0].flg;
        void'(mq.pop_front());
      end else if (clr) begin
        ff_m = 5'd0;
      end
      if (rq && exp_ready) mq.push_back('{tg, d, f, cyc + LAT + 1});
      if (rq && !exp_ready) err_m = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    publish();
  endtask

  task automatic idle(input int n, input bit wr);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, wr, 1'b0, 1'b1, 32'd0, 5'd0);
  endtask

  // Literal expectation checked at this cycle's compare point.
  // sel: 0 valid 1 tag 2 data 3 flag 4 fflags 5 ready 6 busy 7 err
  task automatic pin(input int sel, input logic [31:0] val, input string name);
    pins[pin_wr] = '{sel, val, name};
    pin_wr++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, expv);
    end
  endtask

  // Compare process: DUT outputs against the model every cycle, plus pins.
  always @(negedge clk) begin
    if (run) begin
      logic [31:0] g;
      chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("wb_tag",  32'(wb_tag),  32'(exp_head.tag));
        chk("wb_data", wb_data,      exp_head.data);
        chk("wb_flag", 32'(wb_flag), 32'(exp_head.flg));
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy",      32'(busy),      32'(exp_busy));
      chk("fflags",    32'(fflags),    32'(exp_fflags));
      chk("err",       32'(err),       32'(exp_err));
      while (pin_rd < pin_wr) begin
        case (pins[pin_rd].sel)
          0:       g = 32'(wb_valid);
          1:       g = 32'(wb_tag);
          2:       g = wb_data;
          3:       g = 32'(wb_flag);
          4:       g = 32'(fflags);
          5:       g = 32'(req_ready);
          6:       g = 32'(busy);
          default: g = 32'(err);
        endcase
        chk(pins[pin_rd].name, g, pins[pin_rd].val);
        pin_rd++;
      end
    end
  end

  initial begin
    run = 0; cyc = 0; pin_wr = 0; pin_rd = 0; n_checks = 0; n_fail = 0;
    ff_m = 5'd0; err_m = 1'b0;
    reset = 1'b0; req = 1'b0; req_tag = '0; wb_ready = 1'b0; fflags_clr = 1'b0;
    rslt = '0; flag = '0;
    @(posedge clk);
    #1;
    publish();
    run = 1;
    pin(0, 0, "rst_valid"); pin(5, 1, "rst_ready"); pin(4, 0, "rst_fflags");
    pin(7, 0, "rst_err");   pin(6, 0, "rst_busy");
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
    idle(1, 1'b1);

    // Basic: 1*2+3 = 5, head at issue+3
    step(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 32'h40a00000, 5'h00);
    pin(0, 0, "basic_not_early");
    idle(2, 1'b1);
    pin(0, 1, "basic_valid"); pin(1, 3, "basic_tag");
    pin(2, 32'h40a00000, "basic_data"); pin(3, 0, "basic_flag");
    idle(1, 1'b1);
    pin(4, 0, "basic_fflags"); pin(0, 0, "basic_popped");

    // Back-pressure: tags 1..4 with consumer stalled
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'(i), 1'b0, 1'b0, 1'b1, $urandom, 5'($urandom));
    pin(5, 0, "bp_ready_low");
    idle(6, 1'b0);
    pin(5, 0, "bp_ready_still_low"); pin(1, 1, "bp_tag1");
    idle(1, 1'b1);
    pin(5, 1, "bp_ready_back"); pin(1, 2, "bp_tag2");
    idle(1, 1'b1);
    pin(1, 3, "bp_tag3");
    idle(1, 1'b1);
    pin(1, 4, "bp_tag4");
    idle(1, 1'b1);
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, 5'd0);
    pin(4, 0, "bp_clr");

    // Invalid: inf*0+0 -> default NaN, NV
    step(1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 32'hffc00000, 5'h10);
    idle(2, 1'b0);
    pin(2, 32'hffc00000, "nv_data"); pin(3, 32'h10, "nv_flag");
    idle(1, 1'b1);
    pin(4, 32'h10, "nv_fflags");
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'd0, 5'd0);
    pin(4, 0, "nv_clr");

    // Clear and pop in the same cycle keeps the popped flag
    step(1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 32'hffc00000, 5'h10);
    step(1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'h3f800001, 5'h01);
    idle(2, 1'b0);
    idle(1, 1'b1);
    pin(4, 32'h10, "cp_pre");
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 32'd0, 5'd0);
    pin(4, 32'h01, "cp_collision");

    // Steady state at DEPTH-1 credits used: accept + pop together
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(10 + i), 1'b0, 1'b0, 1'b1, $urandom, 5'($urandom));
    idle(3, 1'b0);
    pin(5, 1, "ss_ready_pre");
    step(1'b1, 5'd13, 1'b1, 1'b0, 1'b1, $urandom, 5'($urandom));
    pin(5, 1, "ss_ready_post"); pin(6, 1, "ss_busy");
    idle(8, 1'b1);
    pin(6, 0, "ss_drained");

    // Reset mid-flight
    step(1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 32'h12345678, 5'h00);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      pin(0, 0, "rmf_no_valid");
      idle(1, 1'b1);
    end
    pin(6, 0, "rmf_busy"); pin(5, 1, "rmf_ready");

    // Request without credit sets err
    pin(7, 0, "err_pre");
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'(20 + i), 1'b0, 1'b0, 1'b1, $urandom, 5'($urandom));
    step(1'b1, 5'd24, 1'b0, 1'b0, 1'b1, $urandom, 5'($urandom));
    pin(7, 1, "err_set");
    idle(4, 1'b1);
    pin(7, 1, "err_sticky");
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0);
    pin(7, 0, "err_reset");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit rq, wr, clr, rn;
      rq  = ($urandom_range(0, 9) < 7);
      wr  = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 9) == 0);
      rn  = ($urandom_range(0, 199) != 0);
      step(rq, 5'($urandom), wr, clr, rn, $urandom, 5'($urandom));
    end
    idle(10, 1'b1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
